// File: rtl/radix4_booth_mult_param.sv
// Sequential radix-4 Booth multiplier: operands arrive as IN_W-bit beats (A then X, LS chunk first),
// one Booth digit is retired per CALC cycle, and the exact 2N-bit product is held in DONE.
module radix4_booth_mult_param #(
  parameter int N    = 16,
  parameter int IN_W = 8
) (
  input  logic            clk,
  input  logic            MSBrst,
  input  logic            start,
  input  logic            signed_mode,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            busy,
  output logic            done,
  output logic [2*N-1:0]  result
);

  localparam int NBEATS = 2 * N / IN_W;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int DW     = $clog2(N / 2 + 1);

  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);
  localparam logic [DW-1:0] DIG_S     = DW'(N / 2 - 1);
  localparam logic [DW-1:0] DIG_U     = DW'(N / 2);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_signed;
  logic [2*N-1:0]  r_ops;      // {X, A}
  logic [BW-1:0]   r_beat;
  logic [DW-1:0]   r_dig;
  logic [N+2:0]    r_acc;
  logic [N+1:0]    r_lo;
  logic [2*N-1:0]  r_result;

  logic            w_beat_ok, w_last_beat, w_last_dig;
  logic [N+2:0]    w_a_ext, w_x_pad, w_pp, w_sum, w_acc_nxt;
  logic [N+1:0]    w_lo_nxt;
  logic [2:0]      w_trip;
  logic [2*N-1:0]  w_product;

  assign w_beat_ok   = in_valid && (r_state == LOAD);
  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_last_dig  = (r_dig == (r_signed ? DIG_S : DIG_U));

  // Operands extended to N+2 bits; X carries the implicit 0 below bit 0.
  assign w_a_ext = {{3{r_signed & r_ops[N-1]}}, r_ops[N-1:0]};
  assign w_x_pad = {{2{r_signed & r_ops[2*N-1]}}, r_ops[2*N-1:N], 1'b0};
  assign w_trip  = w_x_pad[{r_dig, 1'b0} +: 3];

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_pp = '0;
    case (w_trip)
      3'b001, 3'b010: w_pp = w_a_ext;
      3'b011:         w_pp = w_a_ext << 1;
      3'b100:         w_pp = -(w_a_ext << 1);
      3'b101, 3'b110: w_pp = -w_a_ext;
      default:        w_pp = '0;
    endcase
  end

  assign w_sum     = r_acc + w_pp;
  assign w_acc_nxt = {{2{w_sum[N+2]}}, w_sum[N+2:2]};
  assign w_lo_nxt  = {w_sum[1:0], r_lo[N+1:2]};
  // Unsigned mode retires one extra digit, so two more low bits are valid.
  assign w_product = r_signed ? {w_acc_nxt[N-1:0], w_lo_nxt[N+1:2]}
                              : {w_acc_nxt[N-3:0], w_lo_nxt};

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge MSBrst) begin
    if (MSBrst) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_state_nxt = LOAD;
      LOAD:       if (w_beat_ok && w_last_beat) w_state_nxt = CALC;
      CALC:       if (w_last_dig) w_state_nxt = DONE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  // NOTE: the operand store is reset along with everything else so an aborted load leaves nothing behind.
  always_ff @(posedge clk or posedge MSBrst) begin
    if (MSBrst) begin
      r_signed <= 1'b0;
      r_ops    <= '0;
      r_beat   <= '0;
      r_dig    <= '0;
      r_acc    <= '0;
      r_lo     <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_result <= '0;
            r_signed <= signed_mode;
            r_beat   <= '0;
          end
        end
        LOAD: begin
          if (w_beat_ok) begin
            r_ops[int'(r_beat) * IN_W +: IN_W] <= in_data;
            r_beat <= r_beat + 1'b1;
            if (w_last_beat) begin
              r_acc <= '0;
              r_lo  <= '0;
              r_dig <= '0;
            end
          end
        end
        CALC: begin
          r_acc <= w_acc_nxt;
          r_lo  <= w_lo_nxt;
          r_dig <= r_dig + 1'b1;
          if (w_last_dig) r_result <= w_product;
        end
        default: ;
      endcase
    end
  end

  assign in_ready = (r_state == LOAD);
  assign busy     = (r_state == LOAD) || (r_state == CALC);
  assign done     = (r_state == DONE);
  assign result   = r_result;

endmodule

// File: tb/tb_radix4_booth_mult_param.sv
// Scoreboard bench for radix4_booth_mult_param: a driver loads beats and queues the arithmetic
// product; a monitor compares the queue head whenever done rises.
module tb_radix4_booth_mult_param;
  localparam int N    = 16;
  localparam int IN_W = 8;
  localparam int NB   = N / IN_W;

  logic            clk = 1'b0;
  logic            MSBrst, start, signed_mode, in_valid;
  logic [IN_W-1:0] in_data;
  logic            in_ready, busy, done;
  logic [2*N-1:0]  result;

  int checks = 0;
  int errors = 0;
  logic [2*N-1:0] exp_q[$];
  logic done_q = 1'b0;

  radix4_booth_mult_param #(.N(N), .IN_W(IN_W)) dut (
    .clk(clk), .MSBrst(MSBrst), .start(start), .signed_mode(signed_mode),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer multiplication of the operands as interpreted by the mode.
  function automatic logic [2*N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] x, input bit sm);
    longint pa, px, p;
    pa = longint'(a);
    px = longint'(x);
    if (sm && a[N-1]) pa -= (longint'(1) << N);
    if (sm && x[N-1]) px -= (longint'(1) << N);
    p = pa * px;
    return p[2*N-1:0];
  endfunction

  always @(negedge clk) begin
    if (done && !done_q) begin
      if (exp_q.size() == 0) check("sb_unexpected_done", 1, 0);
      else                   check("sb_result", result, exp_q.pop_front());
    end
    done_q = done;
  end

  task automatic load_op(input logic [N-1:0] a, input logic [N-1:0] x, input bit sm, input int max_gap);
    logic [N-1:0] w;
    @(negedge clk);
    start = 1'b1;
    signed_mode = sm;
    @(negedge clk);
    start = 1'b0;
    signed_mode = 1'($urandom);
    check("start_clears_result", result, 0);
    check("start_clears_done", done, 0);
    check("busy_in_load", busy, 1);
    for (int i = 0; i < 2 * NB; i++) begin
      w = (i < NB) ? a : x;
      repeat ($urandom_range(0, max_gap)) begin
        in_valid = 1'b0;
        in_data  = IN_W'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = w[(i % NB) * IN_W +: IN_W];
      check("in_ready_load", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Counts edges from the final beat to done; optionally pulses start during CALC.
  task automatic finish_op(input int k, input int pulse_at);
    int cnt = 0;
    while (!done && cnt < 40) begin
      start    = (cnt == pulse_at);
      in_valid = 1'($urandom);
      in_data  = IN_W'($urandom);
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    check("calc_latency", cnt, k);
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] x, input bit sm,
                        input int max_gap, input int pulse_at);
    exp_q.push_back(model(a, x, sm));
    load_op(a, x, sm, max_gap);
    finish_op(sm ? N / 2 : N / 2 + 1, pulse_at);
  endtask

  initial begin
    MSBrst = 1'b1; start = 1'b0; signed_mode = 1'b0; in_valid = 1'b0; in_data = '0;
    #12;
    check("rst_result", result, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    @(negedge clk);
    MSBrst = 1'b0;

    run_op(16'hFFFF, 16'hFFFF, 1'b1, 0, -1);
    check("signed_m1_m1", result, 32'h0000_0001);
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 0, -1);
    check("unsigned_ffff_ffff", result, 32'hFFFE_0001);
    run_op(16'h8000, 16'h8000, 1'b1, 0, -1);
    check("signed_min_min", result, 32'h4000_0000);
    run_op(16'h7FFF, 16'h8000, 1'b1, 0, -1);
    check("signed_max_min", result, 32'hC000_8000);

    // Gapped beats with a start pulse during CALC, then hold in DONE.
    run_op(16'h1234, 16'hABCD, 1'b1, 3, 3);
    repeat (3) @(negedge clk);
    check("done_hold_result", result, model(16'h1234, 16'hABCD, 1'b1));
    check("done_hold_flag", done, 1);

    // Abort on CALC cycle 4: the negedge after the last beat is CALC cycle 1.
    load_op(16'h1111, 16'h2222, 1'b1, 0);
    repeat (3) @(negedge clk);
    #1 MSBrst = 1'b1;
    #1;
    check("abort_result", result, 0);
    check("abort_done", done, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    @(negedge clk);
    MSBrst = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_stays_idle", busy, 0);
    run_op(16'h0003, 16'hFFFE, 1'b1, 0, -1);
    check("after_abort", result, 32'hFFFF_FFFA);

    for (int i = 0; i < 30; i++)
      run_op(N'($urandom), N'($urandom), 1'($urandom), 2, int'($urandom_range(0, 9)));

    repeat (2) @(negedge clk);
    check("sb_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
